// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one full-adder cell and a carry flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_c;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] sh_s_nxt;

  always_comb begin
    bit_s    = sh_a[0] ^ sh_b[0] ^ c;
    bit_c    = (sh_a[0] & sh_b[0]) | (c & (sh_a[0] ^ sh_b[0]));
    sh_s_nxt = {bit_s, sh_s[WIDTH-1:1]};
    last_bit = (cnt == LAST_CNT);
    // DONE accepts a new request exactly like IDLE, giving back-to-back operation
    load     = start && (state != SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a <= '0;
      sh_b <= '0;
      sh_s <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      sh_a <= a;
      sh_b <= b;
      sh_s <= '0;
      c    <= cin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      sh_s <= sh_s_nxt;
      c    <= bit_c;
      cnt  <= cnt + 1'b1;
      // The result registers move only as the last bit retires, so they hold while busy
      if (last_bit) begin
        sum  <= sh_s_nxt;
        cout <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized bench for serial_adder against an a+b+cin model
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;
  logic [W:0] prev_res = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one add, wait for done with a bound, check latency and result.
  // Returns in the done cycle with start low; hold_start keeps start high that many cycles.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        input int hold_start);
    logic [W:0] exp_res;
    int lat;
    exp_res = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
    start = 1'b1;
    a = oa;
    b = ob;
    cin = oc;
    tick;
    lat = 1;
    while (!done && lat <= W + 10) begin
      check("busy_in_shift", 64'(busy), 64'(1));
      check("sum_hold", 64'({cout, sum}), 64'(prev_res));
      if (lat >= hold_start) start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      tick;
      lat++;
    end
    check("latency", 64'(lat), 64'(W + 1));
    check("result", 64'({cout, sum}), 64'(exp_res));
    check("busy_in_done", 64'(busy), 64'(0));
    prev_res = exp_res;
    start = 1'b0;
  endtask

  initial begin
    int dones;

    rst_n = 1'b0;
    tick;
    tick;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    rst_n = 1'b1;
    tick;

    run_op(8'h3C, 8'h05, 1'b0, 1);
    run_op(8'hFF, 8'h01, 1'b0, 1);
    run_op(8'hFF, 8'hFF, 1'b1, 1);

    // start held high for the whole shift with operands churning: one done only
    tick;
    run_op(8'h5A, 8'h33, 1'b1, W + 2);
    dones = 0;
    repeat (W + 3) begin
      tick;
      if (done) dones++;
    end
    check("single_done", 64'(dones), 64'(0));

    // reset during the fourth shift cycle discards the partial result
    start = 1'b1;
    a = 8'h77;
    b = 8'h99;
    cin = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    prev_res = '0;
    dones = 0;
    repeat (W + 3) begin
      if (done) dones++;
      tick;
    end
    check("no_done_after_rst", 64'(dones), 64'(0));
    run_op(8'h80, 8'h80, 1'b1, 1);

    // relaunch from the done cycle with no dead cycle
    run_op(8'h01, 8'h02, 1'b0, 1);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          tick;
          check("idle_done", 64'(done), 64'(0));
          check("idle_hold", 64'({cout, sum}), 64'(prev_res));
        end
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(1, W + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
